logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
Parametrised, pipelined successor to the combinational ALU logic unit. Performs bitwise ops and signed/unsigned compare on DATA_WIDTH operands. Results travel through STAGES registered stages with valid/ready backpressure. A sticky compare-flag register keeps the last completed compare result for the branch unit. It sits between operand fetch and ALU result writeback, in parallel with the arithmetic unit.

Parameters:
DATA_WIDTH, 32, operand/result width (>=2)
STAGES, 2, pipeline depth in register stages (1..4); latency equals STAGES

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operation presented
in_ready  out  1  stage 0 can accept this cycle
in_a  in  DATA_WIDTH  operand A
in_b  in  DATA_WIDTH  operand B
in_op  in  3  0=AND 1=OR 2=XOR 3=NOT(in_a) 4=NAND 5=NOR 6=XNOR 7=CPR
in_signed  in  1  CPR compares two's-complement when 1, unsigned when 0
out_valid  out  1  result valid in last stage
out_ready  in  1  consumer accepts result
out_data  out  DATA_WIDTH  bitwise result; 0 for CPR
out_flag  out  3  CPR result: 3'b100 equal, 3'b010 a>b, 3'b001 a<b; 3'b000 for non-CPR
out_zero  out  1  out_data == 0 (non-CPR only; 0 for CPR)
cmp_flag_q  out  3  sticky copy of out_flag of the last CPR that completed handshake

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset: all stage valid bits 0, out_valid 0, out_data 0, out_flag 0, out_zero 0, cmp_flag_q 0. rst in mid-operation discards all in-flight ops with no output. in_ready is 0 while rst is high.
- Compute happens combinationally at input and is captured into stage 0 on accept (in_valid && in_ready). Later stages carry the result, flags and zero bit unchanged.
- Stage k advances when it is empty or stage k+1 advances. The last stage advances when it is empty or out_ready is high. in_ready = stage 0 advances.
- Bubbles collapse: an empty stage accepts even while downstream is stalled.
- Latency: accept at edge N gives out_valid at edge N+STAGES-1 with no stall, i.e. STAGES cycles of register delay. Throughput is 1 op/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, out_data/out_flag/out_zero are held stable. No op is dropped or duplicated; order is preserved.
- Output handshake completes when out_valid && out_ready. At that edge, if the op was CPR, cmp_flag_q <= out_flag. Otherwise cmp_flag_q is unchanged.
- Exactly one out_flag bit is set for CPR.
- Signed CPR compares MSB as sign; unsigned compares raw magnitude.
- NOT ignores in_b. in_signed is ignored for non-CPR ops.
- Simultaneous accept and output handshake in a full pipeline is legal and sustains full throughput.
- No combinational path from in_* to out_*. The only combinational path is out_ready -> in_ready.

Test Plan:
- DATA_WIDTH=8, STAGES=2: accept AND a=8'hF0 b=8'h3C at cycle 0, out_ready=1 -> out_valid at cycle 2 with out_data=8'h30, out_flag=0, out_zero=0.
- CPR a=8'h80 b=8'h01: in_signed=1 -> out_flag=3'b001; in_signed=0 -> 3'b010. Equal 8'h55/8'h55 -> 3'b100. cmp_flag_q tracks each completed CPR.
- XOR a=b=8'hA5 -> out_data=0, out_zero=1. Follow with OR 8'h0F/8'hF0 -> cmp_flag_q keeps the previous CPR value, out_data=8'hFF.
- Backpressure: stream 6 ops back-to-back, hold out_ready=0 for 5 cycles -> in_ready drops after STAGES ops are held, outputs stable. On release all 6 ops emerge in order, none lost or duplicated.
- Bubble collapse: one op stalled in the last stage, stage 0 empty -> in_ready=1 and a new op is accepted into stage 0.
- Assert rst for 1 cycle with 2 ops in flight -> next cycle out_valid=0, cmp_flag_q=0, out_data=0. First op after reset completes normally with latency STAGES.

Source files
------------

// File: rtl/logic_unit_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | logic_unit_pipe: pipelined bitwise/compare unit with valid/ready      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module logic_unit_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            in_op,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_flag,
  output logic                  out_zero,
  output logic [2:0]            cmp_flag_q
);

  localparam int LAST = STAGES - 1;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOT  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_CPR  = 3'd7;

  localparam logic [2:0] FLAG_EQ = 3'b100;
  localparam logic [2:0] FLAG_GT = 3'b010;
  localparam logic [2:0] FLAG_LT = 3'b001;

  logic [STAGES-1:0]                 valid_q, valid_d;
  logic [STAGES-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [STAGES-1:0][2:0]            flag_q, flag_d;
  logic [STAGES-1:0]                 zero_q, zero_d;
  logic [2:0]                        cmp_flag_d;

  logic [STAGES-1:0]     adv;
  logic                  accept;
  logic [DATA_WIDTH-1:0] res;
  logic [2:0]            res_flag;
  logic                  res_zero;
  logic                  a_gt_b;

  // Operation decode and compare at the input, ahead of stage 0.
  always_comb begin
    res      = '0;
    res_flag = 3'b000;
    a_gt_b   = in_signed ? ($signed(in_a) > $signed(in_b)) : (in_a > in_b);
    case (in_op)
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_XOR:  res = in_a ^ in_b;
      OP_NOT:  res = ~in_a;
      OP_NAND: res = ~(in_a & in_b);
      OP_NOR:  res = ~(in_a | in_b);
      OP_XNOR: res = ~(in_a ^ in_b);
      default: begin
        if (in_a == in_b) begin
          res_flag = FLAG_EQ;
        end else if (a_gt_b) begin
          res_flag = FLAG_GT;
        end else begin
          res_flag = FLAG_LT;
        end
      end
    endcase
    res_zero = (in_op != OP_CPR) && (res == '0);
  end

  // Stage k can move iff some stage at or after k is empty, or the consumer takes the last one.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) begin
          adv[k] = 1'b1;
        end
      end
    end
  end

  assign in_ready = adv[0] && !rst;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    flag_d     = flag_q;
    zero_d     = zero_q;
    cmp_flag_d = cmp_flag_q;

    if (adv[0]) begin
      valid_d[0] = accept;
      if (accept) begin
        data_d[0] = res;
        flag_d[0] = res_flag;
        zero_d[0] = res_zero;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          flag_d[k] = flag_q[k-1];
          zero_d[k] = zero_q[k-1];
        end
      end
    end

    // Only compares carry a non-zero flag, so that alone marks a CPR leaving.
    if (valid_q[LAST] && out_ready && (flag_q[LAST] != 3'b000)) begin
      cmp_flag_d = flag_q[LAST];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      data_q     <= '0;
      flag_q     <= '0;
      zero_q     <= '0;
      cmp_flag_q <= 3'b000;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      flag_q     <= flag_d;
      zero_q     <= zero_d;
      cmp_flag_q <= cmp_flag_d;
    end
  end

  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];
  assign out_flag  = flag_q[LAST];
  assign out_zero  = zero_q[LAST];

endmodule
`default_nettype wire
